// File: rtl/ama_riscv_mem_arbiter.sv
// Shares one backing memory port between the fetch (imem) and load/store (dmem) requesters.
// dmem has priority, bounded by an imem starvation limit; one transaction in flight at a time.
//
// state    | meaning
// IDLE     | arbitrate between imem and dmem, accept one request
// REQ      | present the latched request to memory until accepted
// WAIT_RSP | wait for the memory response, route it to the owner
module ama_riscv_mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_imem_req_valid,
  output logic          o_imem_req_ready,
  input  logic [AW-1:0] i_imem_req_addr,
  output logic          o_imem_rsp_valid,
  output logic [DW-1:0] o_imem_rsp_data,
  input  logic          i_dmem_req_valid,
  output logic          o_dmem_req_ready,
  input  logic [AW-1:0] i_dmem_req_addr,
  input  logic [DW-1:0] i_dmem_req_wdata,
  input  logic [3:0]    i_dmem_req_wstrb,
  output logic          o_dmem_rsp_valid,
  output logic [DW-1:0] o_dmem_rsp_data,
  output logic          o_mem_req_valid,
  input  logic          i_mem_req_ready,
  output logic [AW-1:0] o_mem_req_addr,
  output logic [DW-1:0] o_mem_req_wdata,
  output logic [3:0]    o_mem_req_wstrb,
  input  logic          i_mem_rsp_valid,
  input  logic [DW-1:0] i_mem_rsp_data,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_IMEM = 1'b0,
    OWNER_DMEM = 1'b1
  } owner_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t        r_state;
  state_t        w_state_nxt;
  owner_t        r_owner;
  logic [3:0]    r_starve_cnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_wstrb;
  logic          r_imem_rsp_valid;
  logic          r_dmem_rsp_valid;
  logic [DW-1:0] r_imem_rsp_data;
  logic [DW-1:0] r_dmem_rsp_data;

  logic w_grant_dmem;
  logic w_grant_imem;
  logic w_hs_imem;
  logic w_hs_dmem;
  logic w_rsp_imem;
  logic w_rsp_dmem;

  // dmem wins unless imem has already lost MAX_WAIT times in a row
  assign w_grant_dmem = i_dmem_req_valid &&
                        ((r_starve_cnt < MAX_WAIT_C) || !i_imem_req_valid);
  assign w_grant_imem = i_imem_req_valid && !w_grant_dmem;

  always_comb begin
    w_state_nxt      = r_state;
    o_imem_req_ready = 1'b0;
    o_dmem_req_ready = 1'b0;
    o_mem_req_valid  = 1'b0;
    w_rsp_imem       = 1'b0;
    w_rsp_dmem       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!rst) begin
          o_imem_req_ready = w_grant_imem;
          o_dmem_req_ready = w_grant_dmem;
          if (w_grant_imem || w_grant_dmem) begin
            w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) begin
          w_state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (i_mem_rsp_valid) begin
          w_rsp_imem  = (r_owner == OWNER_IMEM);
          w_rsp_dmem  = (r_owner == OWNER_DMEM);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_hs_imem = i_imem_req_valid && o_imem_req_ready;
  assign w_hs_dmem = i_dmem_req_valid && o_dmem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_owner          <= OWNER_IMEM;
      r_starve_cnt     <= 4'd0;
      r_imem_rsp_valid <= 1'b0;
      r_dmem_rsp_valid <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_imem_rsp_valid <= w_rsp_imem;
      r_dmem_rsp_valid <= w_rsp_dmem;
      if (w_hs_imem) begin
        r_owner      <= OWNER_IMEM;
        r_starve_cnt <= 4'd0;
      end else if (w_hs_dmem) begin
        r_owner <= OWNER_DMEM;
        if (i_imem_req_valid && (r_starve_cnt != MAX_WAIT_C)) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end
    end
  end

  // Request fields and response data need no reset: qualified by state / rsp_valid
  always_ff @(posedge clk) begin
    if (w_hs_imem) begin
      r_addr  <= i_imem_req_addr;
      r_wdata <= '0;
      r_wstrb <= 4'd0;
    end else if (w_hs_dmem) begin
      r_addr  <= i_dmem_req_addr;
      r_wdata <= i_dmem_req_wdata;
      r_wstrb <= i_dmem_req_wstrb;
    end
    if (w_rsp_imem) begin
      r_imem_rsp_data <= i_mem_rsp_data;
    end
    if (w_rsp_dmem) begin
      r_dmem_rsp_data <= i_mem_rsp_data;
    end
  end

  assign o_mem_req_addr   = r_addr;
  assign o_mem_req_wdata  = r_wdata;
  assign o_mem_req_wstrb  = r_wstrb;
  assign o_imem_rsp_valid = r_imem_rsp_valid;
  assign o_imem_rsp_data  = r_imem_rsp_data;
  assign o_dmem_rsp_valid = r_dmem_rsp_valid;
  assign o_dmem_rsp_data  = r_dmem_rsp_data;
  assign o_busy           = (r_state != IDLE);

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// Directed bench for ama_riscv_mem_arbiter: a memory responder plus scoreboard queues
// for expected memory requests and expected routed responses.
module tb_ama_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_rsp_valid;
  logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_rsp_data;
  logic [3:0]  dmem_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_wstrb;
  logic        busy;

  always #5 clk = ~clk;

  ama_riscv_mem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_imem_req_valid (imem_req_valid),
    .o_imem_req_ready (imem_req_ready),
    .i_imem_req_addr  (imem_req_addr),
    .o_imem_rsp_valid (imem_rsp_valid),
    .o_imem_rsp_data  (imem_rsp_data),
    .i_dmem_req_valid (dmem_req_valid),
    .o_dmem_req_ready (dmem_req_ready),
    .i_dmem_req_addr  (dmem_req_addr),
    .i_dmem_req_wdata (dmem_req_wdata),
    .i_dmem_req_wstrb (dmem_req_wstrb),
    .o_dmem_rsp_valid (dmem_rsp_valid),
    .o_dmem_rsp_data  (dmem_rsp_data),
    .o_mem_req_valid  (mem_req_valid),
    .i_mem_req_ready  (mem_req_ready),
    .o_mem_req_addr   (mem_req_addr),
    .o_mem_req_wdata  (mem_req_wdata),
    .o_mem_req_wstrb  (mem_req_wstrb),
    .i_mem_rsp_valid  (mem_rsp_valid),
    .i_mem_rsp_data   (mem_rsp_data),
    .o_busy           (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    bit          is_dmem;
    logic [31:0] data;
    bit          chk_data;
  } rsp_t;

  req_t        exp_req[$];
  rsp_t        exp_rsp[$];
  logic [31:0] rsp_data_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          lat = 1;
  int          rsp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: accepts on valid&ready, answers lat cycles later, ignores rst
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = (rsp_data_q.size() > 0) ? rsp_data_q.pop_front() : 32'h0;
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) begin
          chk("unexpected_mem_req", mem_req_addr, 32'hFFFF_FFFF);
        end else begin
          req_t e;
          e = exp_req.pop_front();
          chk("mem_req_addr", mem_req_addr, e.addr);
          chk("mem_req_wdata", mem_req_wdata, e.wdata);
          chk("mem_req_wstrb", {28'h0, mem_req_wstrb}, {28'h0, e.wstrb});
        end
        rsp_cnt = lat;
      end
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (imem_rsp_valid && dmem_rsp_valid) begin
        chk("rsp_exclusive", 32'h1, 32'h0);
      end else if (imem_rsp_valid || dmem_rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          chk("unexpected_rsp", {31'h0, dmem_rsp_valid}, 32'hFFFF_FFFF);
        end else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          chk("rsp_owner_dmem", {31'h0, dmem_rsp_valid}, {31'h0, e.is_dmem});
          if (e.chk_data) begin
            chk("rsp_data", e.is_dmem ? dmem_rsp_data : imem_rsp_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_hs(output bit got_dmem);
    bit ok;
    ok = 1'b0;
    got_dmem = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dmem_req_valid && dmem_req_ready) begin
        got_dmem = 1'b1;
        ok = 1'b1;
        break;
      end
      if (imem_req_valid && imem_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL handshake_timeout: got no ready expected ready within 100 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_rsp.size() == 0 && !busy && rsp_cnt == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_drain_timeout: got %0d pending rsp expected 0", name, exp_rsp.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit g;
    rst = 1'b1;
    imem_req_valid = 1'b1; imem_req_addr = 32'h40;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h80;
    dmem_req_wdata = '0;   dmem_req_wstrb = 4'h0;
    mem_req_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_ready", {31'h0, imem_req_ready}, 32'h0);
    chk("rst_dmem_ready", {31'h0, dmem_req_ready}, 32'h0);
    chk("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp_valid", {30'h0, imem_rsp_valid, dmem_rsp_valid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
    @(posedge clk); #1;

    // T1 imem read, response 2 cycles after acceptance
    lat = 2;
    exp_req.push_back('{32'h100, 32'h0, 4'h0});
    rsp_data_q.push_back(32'hDEADBEEF);
    exp_rsp.push_back('{1'b0, 32'hDEADBEEF, 1'b1});
    imem_req_addr = 32'h100; imem_req_valid = 1'b1;
    wait_hs(g);
    chk("t1_grant_dmem", {31'h0, g}, 32'h0);
    imem_req_valid = 1'b0;
    drain("t1");

    // T2 contention: dmem first, then imem
    lat = 1;
    exp_req.push_back('{32'h8000, 32'h0, 4'h0});
    exp_req.push_back('{32'h200, 32'h0, 4'h0});
    rsp_data_q.push_back(32'h1111_2222);
    rsp_data_q.push_back(32'h3333_4444);
    exp_rsp.push_back('{1'b1, 32'h1111_2222, 1'b1});
    exp_rsp.push_back('{1'b0, 32'h3333_4444, 1'b1});
    imem_req_addr = 32'h200; imem_req_valid = 1'b1;
    dmem_req_addr = 32'h8000; dmem_req_wdata = 32'h0; dmem_req_wstrb = 4'h0; dmem_req_valid = 1'b1;
    wait_hs(g);
    chk("t2_first_dmem", {31'h0, g}, 32'h1);
    dmem_req_valid = 1'b0;
    wait_hs(g);
    chk("t2_second_dmem", {31'h0, g}, 32'h0);
    imem_req_valid = 1'b0;
    drain("t2");

    // T3 starvation: D D D D I D D D D I
    imem_req_addr = 32'h300; imem_req_valid = 1'b1;
    dmem_req_addr = 32'h9000; dmem_req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bit dm;
      dm = (k % 5) != 4;
      exp_req.push_back('{dm ? 32'h9000 : 32'h300, 32'h0, 4'h0});
      rsp_data_q.push_back(32'h5000 + k);
      exp_rsp.push_back('{dm, 32'h5000 + k, 1'b1});
    end
    for (int k = 0; k < 10; k++) begin
      wait_hs(g);
      chk("t3_grant_dmem", {31'h0, g}, {31'h0, ((k % 5) != 4)});
    end
    imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
    drain("t3");

    // T4 backpressure on a store held in REQ for 3 cycles
    mem_req_ready = 1'b0;
    exp_req.push_back('{32'h44, 32'h1234_5678, 4'hF});
    rsp_data_q.push_back(32'h0);
    exp_rsp.push_back('{1'b1, 32'h0, 1'b0});
    dmem_req_addr = 32'h44; dmem_req_wdata = 32'h1234_5678; dmem_req_wstrb = 4'hF;
    dmem_req_valid = 1'b1;
    wait_hs(g);
    chk("t4_grant_dmem", {31'h0, g}, 32'h1);
    imem_req_addr = 32'h500; imem_req_valid = 1'b1;
    dmem_req_addr = 32'h504; dmem_req_wstrb = 4'h0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
      chk("t4_addr_stable", mem_req_addr, 32'h44);
      chk("t4_wdata_stable", mem_req_wdata, 32'h1234_5678);
      chk("t4_wstrb_stable", {28'h0, mem_req_wstrb}, 32'hF);
      chk("t4_busy", {31'h0, busy}, 32'h1);
      chk("t4_req_ready", {30'h0, imem_req_ready, dmem_req_ready}, 32'h0);
    end
    @(posedge clk); #1;
    imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    drain("t4");

    // T5 partial store
    exp_req.push_back('{32'h10, 32'hA5A5_A5A5, 4'b0011});
    rsp_data_q.push_back(32'h0);
    exp_rsp.push_back('{1'b1, 32'h0, 1'b0});
    dmem_req_addr = 32'h10; dmem_req_wdata = 32'hA5A5_A5A5; dmem_req_wstrb = 4'b0011;
    dmem_req_valid = 1'b1;
    wait_hs(g);
    dmem_req_valid = 1'b0;
    drain("t5");

    // T6 reset while waiting for the response; the late response is dropped
    lat = 4;
    exp_req.push_back('{32'h600, 32'h0, 4'h0});
    rsp_data_q.push_back(32'hBAD0_BAD0);
    imem_req_addr = 32'h600; imem_req_valid = 1'b1;
    wait_hs(g);
    imem_req_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy && !mem_req_valid) break;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy_after_rst", {31'h0, busy}, 32'h0);
    drain("t6");
    repeat (2) @(posedge clk);
    #1;
    chk("t6_busy_idle", {31'h0, busy}, 32'h0);
    lat = 1;
    exp_req.push_back('{32'h700, 32'h0, 4'h0});
    rsp_data_q.push_back(32'h0BAD_F00D);
    exp_rsp.push_back('{1'b0, 32'h0BAD_F00D, 1'b1});
    imem_req_addr = 32'h700; imem_req_valid = 1'b1;
    wait_hs(g);
    chk("t6_grant_dmem", {31'h0, g}, 32'h0);
    imem_req_valid = 1'b0;
    drain("t6b");

    repeat (3) @(posedge clk);
    chk("exp_req_left", exp_req.size(), 32'h0);
    chk("exp_rsp_left", exp_rsp.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
